// File: rtl/demux14_reg.sv
// ============================================================================
// demux14_reg
// ----------------------------------------------------------------------------
// Registered 1:4 demultiplexer with valid/ready handshaking on every side.
// Input beats are steered to one of four output channels. In mode 0 the
// channel comes from i_sel. In mode 1 a round-robin pointer picks it.
// Each channel is a one-deep register slot that drains on its own, so a
// stalled consumer only blocks beats that are addressed to its own channel.
//
// Ports
//   i_clk                  rising-edge clock
//   i_rst                  synchronous, active-high reset
//   i_d      [WIDTH-1:0]   input data beat
//   i_valid                i_d holds a beat offered for transfer
//   o_ready                the offered beat is accepted this cycle
//   i_sel    [1:0]         channel address, used when i_mode = 0
//   i_mode                 0 = addressed by i_sel, 1 = round-robin
//   o_y_0..o_y_3           registered channel data
//   o_valid_0..o_valid_3   channel holds an undelivered beat
//   i_ready_0..i_ready_3   consumer takes the channel beat this cycle
//   o_beat_cnt [7:0]       wrapping count of accepted input beats
// ============================================================================
module demux14_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_sel,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_y_0,
    output logic [WIDTH-1:0] o_y_1,
    output logic [WIDTH-1:0] o_y_2,
    output logic [WIDTH-1:0] o_y_3,
    output logic             o_valid_0,
    output logic             o_valid_1,
    output logic             o_valid_2,
    output logic             o_valid_3,
    input  logic             i_ready_0,
    input  logic             i_ready_1,
    input  logic             i_ready_2,
    input  logic             i_ready_3,
    output logic [7:0]       o_beat_cnt
);

    // Per-channel slot state: EMPTY has nothing to deliver, FULL holds a beat.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      chan_state [4];
    logic [WIDTH-1:0] chan_data  [4];
    logic [1:0]       rr;
    logic [7:0]       beat_cnt;

    logic [3:0]       consumer_ready;
    logic [1:0]       target;
    logic             accept;

    // Gather the per-channel consumer readies so they can be indexed.
    always_comb begin
        consumer_ready = {i_ready_3, i_ready_2, i_ready_1, i_ready_0};
    end

    // The mode-0 mapping swaps channels 2 and 3 relative to plain binary,
    // so that it is the inverse of the companion 4:1 selector; a selector
    // that is driven with the same i_sel recombines the stream.
    always_comb begin
        target = 2'd0;
        if (i_mode) begin
            target = rr;
        end else begin
            case (i_sel)
                2'b00:   target = 2'd0;
                2'b01:   target = 2'd1;
                2'b11:   target = 2'd2;
                2'b10:   target = 2'd3;
                default: target = 2'd0;
            endcase
        end
    end

    // The target slot can take a new beat when it is empty. It can also take
    // one when its current beat leaves on this same edge. This lets a full
    // channel stream at one beat per cycle. o_ready does not look at i_valid.
    always_comb begin
        o_ready = (chan_state[target] == EMPTY) || consumer_ready[target];
        accept  = i_valid && o_ready;
    end

    // Channel slots, round-robin pointer and beat counter.
    // If an accept and a drain reach the same channel on the same edge, the
    // accept wins. The slot stays FULL and loads the new beat, so no bubble
    // is inserted. i_ready on an EMPTY slot does nothing. Slot data is only
    // written on accept, so a drained channel keeps showing its last beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 4; k++) begin
                chan_state[k] <= EMPTY;
                chan_data[k]  <= '0;
            end
            rr       <= 2'd0;
            beat_cnt <= 8'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && (target == k[1:0])) begin
                    chan_state[k] <= FULL;
                    chan_data[k]  <= i_d;
                end else if ((chan_state[k] == FULL) && consumer_ready[k]) begin
                    chan_state[k] <= EMPTY;
                end
            end
            if (accept) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (i_mode) begin
                    rr <= rr + 2'd1;
                end
            end
        end
    end

    assign o_y_0      = chan_data[0];
    assign o_y_1      = chan_data[1];
    assign o_y_2      = chan_data[2];
    assign o_y_3      = chan_data[3];
    assign o_valid_0  = (chan_state[0] == FULL);
    assign o_valid_1  = (chan_state[1] == FULL);
    assign o_valid_2  = (chan_state[2] == FULL);
    assign o_valid_3  = (chan_state[3] == FULL);
    assign o_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_demux14_reg.sv
// ============================================================================
// tb_demux14_reg
// ----------------------------------------------------------------------------
// Self-checking bench for demux14_reg. A reference model runs next to the
// DUT. It keeps an ordered list of beats that have been accepted but not yet
// delivered, each tagged with its destination channel. Channel occupancy and
// readiness come from that list. Every delivery is checked against the oldest
// pending beat for that channel. Directed scenarios run first, then a
// randomized phase.
// ============================================================================
module tb_demux14_reg;

    localparam int WIDTH = 8;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [WIDTH-1:0] i_d;
    logic             i_valid;
    logic             o_ready;
    logic [1:0]       i_sel;
    logic             i_mode;
    logic [WIDTH-1:0] o_y_0, o_y_1, o_y_2, o_y_3;
    logic             o_valid_0, o_valid_1, o_valid_2, o_valid_3;
    logic             i_ready_0, i_ready_1, i_ready_2, i_ready_3;
    logic [7:0]       o_beat_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef struct {
        int         ch;
        logic [7:0] data;
    } beat_t;

    beat_t      pend[$];
    logic [7:0] exp_y [4];
    int         exp_rr;
    int         exp_cnt;
    int         sel_to_ch [4];

    always #5 i_clk = ~i_clk;

    demux14_reg #(.WIDTH(WIDTH)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_d        (i_d),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_sel      (i_sel),
        .i_mode     (i_mode),
        .o_y_0      (o_y_0),
        .o_y_1      (o_y_1),
        .o_y_2      (o_y_2),
        .o_y_3      (o_y_3),
        .o_valid_0  (o_valid_0),
        .o_valid_1  (o_valid_1),
        .o_valid_2  (o_valid_2),
        .o_valid_3  (o_valid_3),
        .i_ready_0  (i_ready_0),
        .i_ready_1  (i_ready_1),
        .i_ready_2  (i_ready_2),
        .i_ready_3  (i_ready_3),
        .o_beat_cnt (o_beat_cnt)
    );

    function automatic logic [7:0] get_y(input int k);
        case (k)
            0:       return o_y_0;
            1:       return o_y_1;
            2:       return o_y_2;
            default: return o_y_3;
        endcase
    endfunction

    function automatic logic get_v(input int k);
        case (k)
            0:       return o_valid_0;
            1:       return o_valid_1;
            2:       return o_valid_2;
            default: return o_valid_3;
        endcase
    endfunction

    function automatic logic has_pending(input int k);
        foreach (pend[i]) begin
            if (pend[i].ch == k) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int target_of(input logic mode, input logic [1:0] sel);
        return mode ? exp_rr : sel_to_ch[sel];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("o_valid_%0d", k), 32'(get_v(k)), 32'(has_pending(k)));
            checkOutput($sformatf("o_y_%0d", k), 32'(get_y(k)), 32'(exp_y[k]));
        end
        checkOutput("o_beat_cnt", 32'(o_beat_cnt), 32'(exp_cnt));
    endtask

    // Drive one cycle of inputs, check o_ready and deliveries before the
    // edge, advance the model at the edge, and check registered outputs after.
    task automatic applyStimulus(input logic rst, input logic valid, input logic [7:0] d,
                                 input logic [1:0] sel, input logic mode, input logic [3:0] rdy);
        int    t;
        logic  exp_ready;
        logic  acc;
        beat_t b;
        i_rst   = rst;
        i_valid = valid;
        i_d     = d;
        i_sel   = sel;
        i_mode  = mode;
        {i_ready_3, i_ready_2, i_ready_1, i_ready_0} = rdy;
        #1;
        t         = target_of(mode, sel);
        exp_ready = !has_pending(t) || rdy[t];
        acc       = valid && exp_ready;
        checkOutput("o_ready", 32'(o_ready), 32'(exp_ready));
        for (int k = 0; k < 4; k++) begin
            if (has_pending(k) && rdy[k]) begin
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].ch == k) begin
                        checkOutput($sformatf("deliver_ch%0d", k), 32'(get_y(k)), 32'(pend[i].data));
                        pend.delete(i);
                        break;
                    end
                end
            end
        end
        @(posedge i_clk);
        if (rst) begin
            pend.delete();
            for (int k = 0; k < 4; k++) exp_y[k] = 8'h00;
            exp_rr  = 0;
            exp_cnt = 0;
        end else if (acc) begin
            b.ch   = t;
            b.data = d;
            pend.push_back(b);
            exp_y[t] = d;
            exp_cnt  = (exp_cnt + 1) % 256;
            if (mode) exp_rr = (exp_rr + 1) % 4;
        end
        #1;
        checkAll();
    endtask

    initial begin
        sel_to_ch[0] = 0;
        sel_to_ch[1] = 1;
        sel_to_ch[2] = 3;
        sel_to_ch[3] = 2;
        for (int k = 0; k < 4; k++) exp_y[k] = 8'h00;
        exp_rr  = 0;
        exp_cnt = 0;
        $display("[TB] starting demux14_reg bench");

        // Reset and the first cycle after it
        applyStimulus(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'b0000);
        checkOutput("ready_after_reset", 32'(o_ready), 32'd1);

        // Mode 0, i_sel=11 steers to channel 2
        applyStimulus(1'b0, 1'b1, 8'hA5, 2'b11, 1'b0, 4'b0000);
        checkOutput("sel11_valid2", 32'(o_valid_2), 32'd1);
        checkOutput("sel11_y2", 32'(o_y_2), 32'hA5);
        checkOutput("sel11_others", 32'({o_valid_3, o_valid_1, o_valid_0}), 32'd0);
        checkOutput("sel11_cnt", 32'(o_beat_cnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 4'b1111);

        // Mode 1 round-robin, back-to-back, all consumers ready
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h10 + k), 2'b00, 1'b1, 4'b1111);
            checkOutput($sformatf("rr_valid%0d", k), 32'(get_v(k)), 32'd1);
            checkOutput($sformatf("rr_y%0d", k), 32'(get_y(k)), 32'(8'h10 + k));
        end
        applyStimulus(1'b0, 1'b1, 8'h14, 2'b11, 1'b1, 4'b1111);
        checkOutput("rr_wrap_y0", 32'(o_y_0), 32'h14);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 4'b1111);

        // Channel 1 full and stalled, then reloaded while draining
        applyStimulus(1'b0, 1'b1, 8'h21, 2'b01, 1'b0, 4'b0000);
        i_valid = 1'b1; i_d = 8'h22; i_sel = 2'b01; i_mode = 1'b0;
        {i_ready_3, i_ready_2, i_ready_1, i_ready_0} = 4'b0000;
        #1;
        checkOutput("stall_ready", 32'(o_ready), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'h22, 2'b01, 1'b0, 4'b0000);
        checkOutput("stall_y1_held", 32'(o_y_1), 32'h21);
        i_ready_1 = 1'b1;
        #1;
        checkOutput("reload_ready", 32'(o_ready), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'h23, 2'b01, 1'b0, 4'b0010);
        checkOutput("reload_y1", 32'(o_y_1), 32'h23);
        checkOutput("reload_valid1", 32'(o_valid_1), 32'd1);

        // Channel 3 stalled does not block channel 0
        applyStimulus(1'b0, 1'b1, 8'h31, 2'b10, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b1, 8'h30, 2'b00, 1'b0, 4'b0000);
        checkOutput("indep_valid0", 32'(o_valid_0), 32'd1);
        checkOutput("indep_valid3", 32'(o_valid_3), 32'd1);

        // Reset with an acceptable beat offered and several channels full
        applyStimulus(1'b1, 1'b1, 8'hFF, 2'b11, 1'b0, 4'b0000);
        checkOutput("rst_valids", 32'({o_valid_3, o_valid_2, o_valid_1, o_valid_0}), 32'd0);
        checkOutput("rst_ys", {o_y_3, o_y_2, o_y_1, o_y_0}, 32'd0);
        checkOutput("rst_cnt", 32'(o_beat_cnt), 32'd0);
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'h55, 2'b11, 1'b1, 4'b0000);
        checkOutput("rst_rr_y0", 32'(o_y_0), 32'h55);
        checkOutput("rst_rr_valid0", 32'(o_valid_0), 32'd1);

        // Beat counter wrap
        applyStimulus(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'b0000);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 2'b00, 1'b1, 4'b1111);
        end
        checkOutput("cnt_wrap0", 32'(o_beat_cnt), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'hEE, 2'b00, 1'b1, 4'b1111);
        checkOutput("cnt_wrap1", 32'(o_beat_cnt), 32'd1);

        // Randomized traffic
        applyStimulus(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'b0000);
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          1'($urandom_range(0, 3) != 0),
                          8'($urandom),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
